// File: rtl/store_monitor_pkg.sv
// Shared types and default constants for the store monitor: FSM encoding,
// pass value, console address and timeout.
package store_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PASSED = 2'd1,
    ST_FAILED = 2'd2
  } state_t;

  localparam logic [31:0] DEF_PASS_VALUE   = 32'd2201;
  localparam logic [31:0] DEF_CONSOLE_ADDR = 32'hFFFF_FFF8;
  localparam logic [31:0] DEF_TIMEOUT      = 32'd500000;
  localparam logic [31:0] CNT_MAX          = 32'hFFFF_FFFF;

endpackage

// File: rtl/console_fifo.sv
// Console character FIFO with registered not-empty flag and sticky overflow.
// Handshake: a pop happens on a rising clk edge where valid && ready are both 1;
// a push into a full FIFO is accepted only if a pop happens on the same edge.
module console_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             pop;
  logic             push_ok;

  assign full    = (count == FULL_CNT);
  assign valid   = (count != '0);
  assign pop     = valid && ready;
  assign push_ok = push && (!full || pop);
  // Gate the read port so the output is zero whenever nothing is queued.
  assign data    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/store_monitor.sv
// Watches processor stores: decides pass/timeout, counts stores and cycles,
// and forwards console-address stores into the console FIFO.
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter logic [31:0] PASS_VALUE   = DEF_PASS_VALUE,
  parameter logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
  parameter logic [31:0] TIMEOUT      = DEF_TIMEOUT,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  input  logic        console_ready,
  output logic        console_valid,
  output logic [7:0]  console_data,
  output logic        done,
  output logic        pass,
  output logic        overflow,
  output logic [31:0] store_count,
  output logic [31:0] end_cycle,
  output logic [1:0]  fsm_state
);

  state_t      state;
  state_t      next_state;
  logic [31:0] cycle_cnt;
  logic        is_console;
  logic        pass_cond;
  logic        timeout_hit;
  logic        leave_run;

  assign is_console  = memwrite && (dataadr == CONSOLE_ADDR);
  assign pass_cond   = memwrite && (dataadr != CONSOLE_ADDR) && (writedata == PASS_VALUE);
  assign timeout_hit = (cycle_cnt == TIMEOUT - 32'd1);
  assign fsm_state   = state;

  // Pass has priority over timeout when both land on the same edge.
  always_comb begin
    next_state = state;
    leave_run  = 1'b0;
    case (state)
      ST_RUN: begin
        if (pass_cond)        next_state = ST_PASSED;
        else if (timeout_hit) next_state = ST_FAILED;
        leave_run = (next_state != ST_RUN);
      end
      default: next_state = state;
    endcase
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      cycle_cnt   <= '0;
      end_cycle   <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      store_count <= '0;
    end else begin
      state <= next_state;
      done  <= (next_state != ST_RUN);
      pass  <= (next_state == ST_PASSED);
      if (state == ST_RUN) cycle_cnt <= cycle_cnt + 32'd1;
      if (leave_run)       end_cycle <= cycle_cnt;
      if (memwrite && (store_count != CNT_MAX)) store_count <= store_count + 32'd1;
    end
  end

  console_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk      (ph1),
    .rst_n    (reset),
    .push     (is_console),
    .push_data(writedata[7:0]),
    .ready    (console_ready),
    .valid    (console_valid),
    .data     (console_data),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_store_monitor.sv
// Directed bench for store_monitor: one instance with default parameters and one
// with TIMEOUT=50 share all inputs; console output is checked against an expected queue.
module tb_store_monitor;
  import store_monitor_pkg::*;

  localparam logic [31:0] CADDR = 32'hFFFF_FFF8;

  logic        ph1;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        console_ready;

  logic        console_valid, t_console_valid;
  logic [7:0]  console_data, t_console_data;
  logic        done, t_done;
  logic        pass, t_pass;
  logic        overflow, t_overflow;
  logic [31:0] store_count, t_store_count;
  logic [31:0] end_cycle, t_end_cycle;
  logic [1:0]  fsm_state, t_fsm_state;

  logic [7:0] exp_q[$];
  int checks;
  int errors;

  store_monitor dut (
    .ph1(ph1), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .console_ready(console_ready),
    .console_valid(console_valid), .console_data(console_data),
    .done(done), .pass(pass), .overflow(overflow),
    .store_count(store_count), .end_cycle(end_cycle), .fsm_state(fsm_state)
  );

  store_monitor #(.TIMEOUT(32'd50)) dut_t (
    .ph1(ph1), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .console_ready(console_ready),
    .console_valid(t_console_valid), .console_data(t_console_data),
    .done(t_done), .pass(t_pass), .overflow(t_overflow),
    .store_count(t_store_count), .end_cycle(t_end_cycle), .fsm_state(t_fsm_state)
  );

  // clock / reset
  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"},   console_valid,   32'd0);
    chk({tag, "_data"},    console_data,    32'd0);
    chk({tag, "_done"},    done,            32'd0);
    chk({tag, "_pass"},    pass,            32'd0);
    chk({tag, "_ovf"},     overflow,        32'd0);
    chk({tag, "_stores"},  store_count,     32'd0);
    chk({tag, "_end"},     end_cycle,       32'd0);
    chk({tag, "_state"},   fsm_state,       32'(ST_RUN));
    chk({tag, "_t_done"},  t_done,          32'd0);
    chk({tag, "_t_valid"}, t_console_valid, 32'd0);
    chk({tag, "_t_end"},   t_end_cycle,     32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge ph1);
    #1;
    check_reset_vals("reset");
    reset = 1'b1;
  endtask

  // driver
  task automatic store(input logic [31:0] adr, input logic [31:0] dat);
    memwrite  = 1'b1;
    dataadr   = adr;
    writedata = dat;
    tick();
    memwrite  = 1'b0;
    dataadr   = '0;
    writedata = '0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (console_valid && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_valid", console_valid, 32'd0);
    chk("drain_queue_empty", exp_q.size(), 32'd0);
  endtask

  // scoreboard monitor: compares every accepted console character
  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge ph1);
      if (reset && console_valid && console_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL console_unexpected actual=%0h required=none", console_data);
        end else begin
          e = exp_q.pop_front();
          chk("console_data", console_data, e);
        end
      end
    end
  endtask

  initial begin
    logic [7:0] ch;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    memwrite = 1'b0;
    dataadr = '0;
    writedata = '0;
    console_ready = 1'b0;
    fork
      monitor();
    join_none

    // Timeout on the TIMEOUT=50 instance, then pass at cycle 100 on the default one.
    do_reset();
    idle(49);
    chk("t_done_before_timeout", t_done, 32'd0);
    idle(1);
    chk("t_done_timeout", t_done, 32'd1);
    chk("t_pass_timeout", t_pass, 32'd0);
    chk("t_end_cycle_timeout", t_end_cycle, 32'd49);
    chk("t_state_failed", t_fsm_state, 32'(ST_FAILED));
    idle(50);
    chk("done_before_pass", done, 32'd0);
    store(32'h54, 32'd2201);
    chk("done_pass", done, 32'd1);
    chk("pass_pass", pass, 32'd1);
    chk("end_cycle_pass", end_cycle, 32'd100);
    chk("state_passed", fsm_state, 32'(ST_PASSED));
    chk("t_pass_after_late_store", t_pass, 32'd0);
    chk("t_end_cycle_held", t_end_cycle, 32'd49);
    chk("store_count_one", store_count, 32'd1);

    // Pass and timeout on the same edge.
    do_reset();
    idle(49);
    store(32'h54, 32'd2201);
    chk("t_pass_tie", t_pass, 32'd1);
    chk("t_state_tie", t_fsm_state, 32'(ST_PASSED));
    chk("t_end_cycle_tie", t_end_cycle, 32'd49);
    idle(3);
    chk("t_pass_tie_held", t_pass, 32'd1);

    // Overflow with 9 characters held back, then drain in order.
    do_reset();
    console_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ch = 8'(8'h41 + i);
      if (i < 8) exp_q.push_back(ch);
      store(CADDR, {24'h0, ch});
      if (i == 7) chk("ovf_at_eight", overflow, 32'd0);
    end
    chk("ovf_at_nine", overflow, 32'd1);
    chk("valid_full", console_valid, 32'd1);
    chk("data_stable", console_data, 32'h41);
    chk("store_count_nine", store_count, 32'd9);
    chk("console_no_pass", done, 32'd0);
    console_ready = 1'b1;
    wait_drain(20);
    exp_q.push_back(8'h99);
    store(CADDR, 32'd2201);
    chk("console_2201_pass", pass, 32'd0);
    chk("console_2201_done", done, 32'd0);
    wait_drain(20);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    console_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ch = 8'(8'h61 + i);
      exp_q.push_back(ch);
      store(CADDR, {24'h0, ch});
    end
    console_ready = 1'b1;
    exp_q.push_back(8'h69);
    store(CADDR, 32'h69);
    chk("ovf_push_pop_full", overflow, 32'd0);
    wait_drain(20);
    chk("ovf_after_drain", overflow, 32'd0);

    // Reset with queued characters and a passed test.
    do_reset();
    console_ready = 1'b0;
    store(CADDR, 32'h78);
    store(CADDR, 32'h79);
    store(CADDR, 32'h7A);
    store(32'h54, 32'd2201);
    chk("pre_reset_pass", pass, 32'd1);
    chk("pre_reset_valid", console_valid, 32'd1);
    chk("pre_reset_data", console_data, 32'h78);
    chk("pre_reset_stores", store_count, 32'd4);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("async");
    repeat (2) @(posedge ph1);
    #1;
    reset = 1'b1;
    store(32'h10, 32'd5);
    chk("restart_stores", store_count, 32'd1);
    chk("restart_valid", console_valid, 32'd0);
    chk("restart_done", done, 32'd0);
    console_ready = 1'b1;
    idle(3);
    chk("restart_queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_monitor.md
STORE_MONITOR -- requirements
Module: store_monitor

Interface
REQ-001 Parameter PASS_VALUE, 32'd2201, store data value that signals test success.
REQ-002 Parameter CONSOLE_ADDR, 32'hFFFF_FFF8, store address that is treated as a console character write.
REQ-003 Parameter TIMEOUT, 32'd500000, cycles allowed in RUN before a test is declared failed.
REQ-004 Parameter FIFO_DEPTH, 8, console FIFO entries (power of two, at least 2).
REQ-005 ph1  input  1  the only clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 memwrite  input  1  processor store strobe, sampled each ph1 edge.
REQ-008 dataadr  input  32  store address.
REQ-009 writedata  input  32  store data.
REQ-010 console_ready  input  1  sink accepts console_data this cycle.
REQ-011 console_valid  output  1  console_data holds a valid character.
REQ-012 console_data  output  8  oldest console character.
REQ-013 done  output  1  test finished (passed or timed out).
REQ-014 pass  output  1  test finished with success.
REQ-015 overflow  output  1  sticky flag: a console character was dropped.
REQ-016 store_count  output  32  number of memwrite cycles since reset.
REQ-017 end_cycle  output  32  cycle count frozen at the moment done rises.

Function
REQ-018 The FSM SHALL have states RUN, PASSED and FAILED; reset enters RUN.
- RUN -> PASSED: memwrite=1, dataadr!=CONSOLE_ADDR, writedata==PASS_VALUE.
- RUN -> FAILED: cycle counter == TIMEOUT-1 and no pass condition that cycle.
- PASSED and FAILED are terminal until reset.
REQ-019 If the pass condition and timeout occur in the same cycle, the block SHALL enter PASSED.
REQ-020 done SHALL be 1 in PASSED or FAILED, and pass SHALL be 1 only in PASSED; both are registered and rise one cycle after the qualifying edge.
REQ-021 The cycle counter SHALL increment every cycle in RUN, starting at 0 after reset, and hold in terminal states.
REQ-022 end_cycle SHALL load the counter value on the transition edge out of RUN and hold it afterwards.
REQ-023 store_count SHALL increment on every memwrite=1 cycle in every state and saturate at 32'hFFFF_FFFF.
REQ-024 A memwrite to CONSOLE_ADDR SHALL push writedata[7:0] into the FIFO in every state and SHALL never satisfy the pass condition.
REQ-025 A pop SHALL occur when console_valid && console_ready; console_valid SHALL equal "FIFO not empty" and be registered, so a push into an empty FIFO shows valid the next cycle.
REQ-026 A push while the FIFO is full SHALL be dropped and set overflow, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-027 A simultaneous push and pop on a non-empty FIFO SHALL keep the occupancy unchanged and preserve order.
REQ-028 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 console_data SHALL be stable while console_valid=1 and console_ready=0.

Reset
REQ-030 reset low SHALL immediately force the following values, regardless of ph1: state=RUN, counter=0, store_count=0, end_cycle=0, done=0, pass=0, overflow=0, FIFO empty, console_valid=0, console_data=0.
REQ-031 Reset asserted during a console transfer or mid-test SHALL discard all FIFO contents and results.
REQ-032 Operation SHALL resume on the first ph1 edge after reset is released.

Structure
REQ-033 State encodings and the default values of PASS_VALUE, CONSOLE_ADDR and TIMEOUT SHALL live in a shared include/package, store_monitor_pkg.
REQ-034 The FIFO SHALL be a separate sub-module, console_fifo, parameterized by depth and width, with the same reset style.
REQ-035 The top-level block SHALL contain only the FSM, the counters and the decode logic.

Verification
REQ-036 Store writedata=2201 to address 0x54 at cycle 100 -> done=1 and pass=1 at cycle 101, and end_cycle=100.
REQ-037 Make no qualifying store with TIMEOUT=50 -> done=1 and pass=0 one cycle after counter=49; end_cycle=49; a later store of 2201 leaves pass=0.
REQ-038 Store 2201 in the same cycle the counter reaches TIMEOUT-1 -> the block ends in PASSED.
REQ-039 Hold console_ready=0 and make 9 stores of 'A'..'I' to CONSOLE_ADDR -> 8 entries held and overflow=1; then raise console_ready -> 'A'..'H' drained in order, then console_valid=0.
REQ-040 Store 2201 to CONSOLE_ADDR -> pass=0 and 8'h99 is queued; a full FIFO with push and pop in the same cycle -> push accepted and overflow=0.
REQ-041 Assert reset with 3 characters queued and PASSED reached -> all outputs return to their reset values; store_count restarts from 0.
